irq_ctrl: RTL

Programmable interrupt controller sitting between peripheral interrupt lines and the coprocessor-0 `interrupt_source[7:0]` input. It latches up to 8 requests (level or rising-edge per source), masks them, picks the highest-priority eligible source and drives it one-hot to CP0. Software claims and completes interrupts through a small memory-mapped register window on the data bus, and the block tracks in-service state so a source is not re-raised while its handler runs.

---
 rtl/irq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source priority interrupt controller feeding CP0 interrupt_source (request to output: 2 cycles, no backpressure).
// Claim/complete through a small register window; define IRQ_CTRL_NEST_EN to let higher sources preempt an in-service one.
module irq_ctrl #(
   parameter int N_SRC = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  irq_in,
   input  logic [2:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [63:0] wr_data,
   output logic [63:0] rd_data,
   output logic [7:0]  interrupt_source,
   output logic        busy
);

   localparam logic [7:0] SRC_MASK = 8'((16'd1 << N_SRC) - 16'd1);

   localparam logic [2:0] A_PENDING    = 3'd0;
   localparam logic [2:0] A_ENABLE     = 3'd1;
   localparam logic [2:0] A_EDGE       = 3'd2;
   localparam logic [2:0] A_CLAIM      = 3'd3;
   localparam logic [2:0] A_IN_SERVICE = 3'd4;

   // Encoding keeps busy equal to state bit 1 so it comes straight off a flop.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_SERVICE = 2'b10,
      ST_PREEMPT = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  irq_q, pending, enable, edge_sel, in_service;
   logic [7:0]  pending_d, enable_d, edge_sel_d, in_service_d;
   logic [7:0]  eligible, eligible_d, edge_det;
   logic [7:0]  claim_mask, cmpl_mask, w1c_mask;
   logic        sel_vld, claim_fire;
   logic [2:0]  sel_id, cmpl_id;
   logic        unused_wr_data;

   assign unused_wr_data = ^wr_data[63:8];

   function automatic logic [7:0] eligible_f(input logic [7:0] pend,
                                             input logic [7:0] en,
                                             input logic [7:0] svc);
      logic [7:0] cand;
      cand = pend & en & ~svc;
`ifdef IRQ_CTRL_NEST_EN
      for (int i = 0; i < 8; i++) begin
         if (svc[i]) cand = cand & (8'hFF << (i + 1));
      end
`else
      if (svc != 8'd0) cand = 8'd0;
`endif
      return cand;
   endfunction

   assign eligible = eligible_f(pending, enable, in_service);

   // Ascending scan so the highest eligible index wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_id  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eligible[i]) begin
            sel_vld = 1'b1;
            sel_id  = 3'(i);
         end
      end
   end

   assign edge_det   = irq_in & ~irq_q;
   assign claim_fire = rd_en && (addr == A_CLAIM) && sel_vld;
   assign claim_mask = claim_fire ? (8'd1 << sel_id) : 8'd0;
   assign cmpl_id    = wr_data[2:0];
   assign cmpl_mask  = (wr_en && (addr == A_CLAIM) && (int'(cmpl_id) < N_SRC))
                       ? (8'd1 << cmpl_id) : 8'd0;
   assign w1c_mask   = (wr_en && (addr == A_PENDING)) ? wr_data[7:0] : 8'd0;

   // Edge-type set wins over a same-cycle W1C or claim clear.
   assign pending_d    = SRC_MASK & ((~edge_sel & irq_in) |
                         (edge_sel & (edge_det | (pending & ~w1c_mask & ~claim_mask))));
   assign in_service_d = SRC_MASK & ((in_service & ~cmpl_mask) | claim_mask);
   assign enable_d     = (wr_en && (addr == A_ENABLE)) ? (wr_data[7:0] & SRC_MASK) : enable;
   assign edge_sel_d   = (wr_en && (addr == A_EDGE))   ? (wr_data[7:0] & SRC_MASK) : edge_sel;
   assign eligible_d   = eligible_f(pending_d, enable_d, in_service_d);

   always_comb begin
      state_d = ST_IDLE;
      if (in_service_d != 8'd0) begin
         state_d = (eligible_d != 8'd0) ? ST_PREEMPT : ST_SERVICE;
      end else if (eligible_d != 8'd0) begin
         state_d = ST_REQ;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         irq_q            <= 8'd0;
         pending          <= 8'd0;
         enable           <= 8'd0;
         edge_sel         <= 8'd0;
         in_service       <= 8'd0;
         interrupt_source <= 8'd0;
      end else begin
         state_q          <= state_d;
         irq_q            <= irq_in;
         pending          <= pending_d;
         enable           <= enable_d;
         edge_sel         <= edge_sel_d;
         in_service       <= in_service_d;
         interrupt_source <= sel_vld ? (8'd1 << sel_id) : 8'd0;
      end
   end

   assign busy = state_q[1];

   always_comb begin
      rd_data = 64'd0;
      case (addr)
         A_PENDING:    rd_data[7:0] = pending;
         A_ENABLE:     rd_data[7:0] = enable;
         A_EDGE:       rd_data[7:0] = edge_sel;
         A_CLAIM: begin
            rd_data[8]   = sel_vld;
            rd_data[2:0] = sel_id;
         end
         A_IN_SERVICE: rd_data[7:0] = in_service;
         default:      rd_data = 64'd0;
      endcase
   end

endmodule
